// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and default sizing for the request controller and its FIFO.
package mem_req_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request, response and memory-side signals of the controller bundled together.
interface mem_req_ctrl_if
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // The controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
    );

    // Upstream requester, downstream consumer and memory, seen from outside.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
    );

endinterface

// File: rtl/mem_req_ctrl_req_fifo.sv
// Synchronous FIFO holding queued commands; head entry is visible combinationally.
module req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty come from the registered count only, so a pop never frees a slot the same cycle.
    always_comb begin
        full     = (count_q == (PTR_W+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_req_ctrl.sv
// Queues read/write requests and issues them one at a time to a single-port memory,
// returning read data through a valid/ready response channel.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    mem_req_ctrl_if.slave  bus
);

    localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    cmd_t                  push_cmd, head_cmd;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign push_cmd  = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    assign fifo_push = bus.req_valid && !fifo_full;

    req_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head_data (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = head_cmd;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD:     state_d = cmd_q.we ? ST_IDLE : ST_RD_WAIT;
            // Memory returns read data one cycle after rd_en, i.e. during this state.
            ST_RD_WAIT: begin
                rsp_rdata_d = bus.mem_rd_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = !fifo_full;
        bus.mem_addr    = cmd_q.addr;
        bus.mem_wr_data = cmd_q.wdata;
        bus.mem_wr_en   = (state_q == ST_CMD) && cmd_q.we;
        bus.mem_rd_en   = (state_q == ST_CMD) && !cmd_q.we;
        bus.rsp_valid   = rsp_valid_q;
        bus.rsp_rdata   = rsp_rdata_q;
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: memory model, in-order reference of expected read data,
// and one task per scenario.
module tb_mem_req_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_req_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    mem_req_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Memory block the controller talks to: synchronous write, registered read.
    bit [7:0] mem_model [8];
    bit [7:0] mem_rd_q;
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem_model[bus.mem_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) mem_rd_q <= mem_model[bus.mem_addr];
    end
    assign bus.mem_rd_data = mem_rd_q;

    // Reference: requests take effect in acceptance order, so a read returns the
    // latest value written to its address by any earlier accepted request.
    bit [7:0] ref_mem [8];
    bit [7:0] exp_q [$];
    bit [7:0] got_q [$];
    int accepted = 0, rsp_cycles = 0, wr_pulses = 0, rd_pulses = 0;
    int viol_both = 0, viol_stable = 0;
    logic [2:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;
    bit hold_prev = 1'b0;
    logic [7:0] prev_rdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                accepted++;
                $display("[%0t] req we=%0b addr=%0d wdata=%02h", $time, bus.req_we, bus.req_addr, bus.req_wdata);
                if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
                else            exp_q.push_back(ref_mem[bus.req_addr]);
            end
            if (bus.rsp_valid) rsp_cycles++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_rdata);
                $display("[%0t] rsp rdata=%02h", $time, bus.rsp_rdata);
            end
            if (bus.mem_wr_en) begin
                wr_pulses++;
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_wr_data;
            end
            if (bus.mem_rd_en) rd_pulses++;
            if (bus.mem_wr_en && bus.mem_rd_en) viol_both++;
            if (hold_prev && (!bus.rsp_valid || bus.rsp_rdata !== prev_rdata)) viol_stable++;
            hold_prev  = bus.rsp_valid && !bus.rsp_ready;
            prev_rdata = bus.rsp_rdata;
        end
    end

    // Present one request from posedge+1; returns at posedge+1 after acceptance or budget expiry.
    task automatic send(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input int budget, output bit ok);
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (got_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 7;
        if (bus.req_ready !== 1'b1)    begin bad++; $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0)    begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 8'h00)   begin bad++; $display("FAIL rst_rsp_rdata got=%h want=00", bus.rsp_rdata); end
        if (bus.mem_addr !== 3'd0)     begin bad++; $display("FAIL rst_mem_addr got=%h want=0", bus.mem_addr); end
        if (bus.mem_wr_en !== 1'b0)    begin bad++; $display("FAIL rst_mem_wr_en got=%b want=0", bus.mem_wr_en); end
        if (bus.mem_rd_en !== 1'b0)    begin bad++; $display("FAIL rst_mem_rd_en got=%b want=0", bus.mem_rd_en); end
        if (bus.mem_wr_data !== 8'h00) begin bad++; $display("FAIL rst_mem_wr_data got=%h want=00", bus.mem_wr_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", bus.req_ready); end
        if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            bad++; $display("FAIL post_rst_enables got=%b%b want=00", bus.mem_wr_en, bus.mem_rd_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        bit ok1, ok2, okd;
        int wr0, rc0;
        bus.rsp_ready = 1'b1;
        wr0 = wr_pulses;
        rc0 = rsp_cycles;
        send(1'b1, 3'd3, 8'hA5, 4, ok1);
        send(1'b0, 3'd3, 8'h00, 8, ok2);
        wait_drain(40, okd);
        total += 7;
        if (!(ok1 && ok2 && okd))      begin bad++; $display("FAIL wr_rd_handshake got=%b%b%b want=111", ok1, ok2, okd); end
        if (wr_pulses - wr0 !== 1)     begin bad++; $display("FAIL wr_rd_wr_pulses got=%0d want=1", wr_pulses - wr0); end
        if (last_wr_addr !== 3'd3)     begin bad++; $display("FAIL wr_rd_wr_addr got=%0d want=3", last_wr_addr); end
        if (last_wr_data !== 8'hA5)    begin bad++; $display("FAIL wr_rd_wr_data got=%h want=a5", last_wr_data); end
        if (rsp_cycles - rc0 !== 1)    begin bad++; $display("FAIL wr_rd_rsp_cycles got=%0d want=1", rsp_cycles - rc0); end
        if (got_q.size() !== 1)        begin bad++; $display("FAIL wr_rd_rsp_count got=%0d want=1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin bad++; $display("FAIL wr_rd_rdata got=%h want=a5", got_q[0]); end
        else if (got_q.size() == 0)    begin bad++; $display("FAIL wr_rd_rdata got=none want=a5"); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok, okd;
        int acc0, nok;
        bus.rsp_ready = 1'b0;
        acc0 = accepted;
        send(1'b0, 3'($urandom), 8'h00, 4, ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_stall_rsp got=0 want=1"); end
        nok = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'($urandom), 3'($urandom), 8'($urandom), 1, ok);
            if (ok) nok++;
        end
        total += 2;
        if (nok !== 4)              begin bad++; $display("FAIL bp_four_queued got=%0d want=4", nok); end
        if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", bus.req_ready); end
        send(1'b0, 3'($urandom), 8'h00, 6, ok);
        total += 2;
        if (ok !== 1'b0)            begin bad++; $display("FAIL bp_fifth_blocked got=%b want=0", ok); end
        if (accepted - acc0 !== 5)  begin bad++; $display("FAIL bp_accepted got=%0d want=5", accepted - acc0); end
        bus.rsp_ready = 1'b1;
        send(1'b0, 3'($urandom), 8'h00, 10, ok);
        wait_drain(100, okd);
        total += 3;
        if (ok !== 1'b1)            begin bad++; $display("FAIL bp_fifth_after_pop got=%b want=1", ok); end
        if (accepted - acc0 !== 6)  begin bad++; $display("FAIL bp_accepted_final got=%0d want=6", accepted - acc0); end
        if (!okd || got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL bp_rsp_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_rdata[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        bit ok, okd;
        int rd0;
        logic [7:0] d;
        d = 8'($urandom);
        bus.rsp_ready = 1'b0;
        send(1'b1, 3'd7, d, 4, ok);
        send(1'b0, 3'd7, 8'h00, 6, ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin ok = 1'b1; break; end
        end
        rd0 = rd_pulses;
        total++;
        if (!ok) begin bad++; $display("FAIL stall_rsp_seen got=0 want=1"); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total += 2;
            if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", c, bus.rsp_valid); end
            if (bus.rsp_rdata !== d)    begin bad++; $display("FAIL stall_rdata[%0d] got=%h want=%h", c, bus.rsp_rdata, d); end
        end
        total++;
        if (rd_pulses !== rd0) begin bad++; $display("FAIL stall_extra_rd got=%0d want=%0d", rd_pulses, rd0); end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_drain(40, okd);
        total++;
        if (!okd || got_q.size() !== 1 || got_q[0] !== d) begin
            bad++; $display("FAIL stall_final_rsp got_n=%0d want_n=1 want=%h", got_q.size(), d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wrap();
        bit ok, okd;
        int nok = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 3'(i), 8'(8'h10 + i), 10, ok);
            if (ok) nok++;
        end
        for (int i = 7; i >= 0; i--) begin
            send(1'b0, 3'(i), 8'h00, 10, ok);
            if (ok) nok++;
        end
        wait_drain(200, okd);
        total += 2;
        if (nok !== 16) begin bad++; $display("FAIL wrap_accepted got=%0d want=16", nok); end
        if (!okd || got_q.size() !== 8) begin bad++; $display("FAIL wrap_rsp_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            total++;
            if (got_q[i] !== 8'(8'h17 - i)) begin
                bad++; $display("FAIL wrap_rdata[%0d] got=%h want=%h", i, got_q[i], 8'(8'h17 - i));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit ok, okd;
        int nok = 0;
        for (int i = 0; i < 40; i++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            send(1'($urandom), 3'($urandom), 8'($urandom), 3, ok);
            if (!ok) begin
                bus.rsp_ready = 1'b1;
                send(bus.req_we, bus.req_addr, bus.req_wdata, 20, ok);
            end
            if (ok) nok++;
        end
        bus.rsp_ready = 1'b1;
        wait_drain(300, okd);
        total += 2;
        if (nok !== 40) begin bad++; $display("FAIL rand_accepted got=%0d want=40", nok); end
        if (!okd || got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_rsp_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_rdata[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok, okd;
        int rd0;
        logic [2:0] a;
        logic [7:0] d;
        a = 3'($urandom);
        d = 8'($urandom);
        bus.rsp_ready = 1'b1;
        send(1'b0, a, 8'h00, 4, ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_rd_issued got=0 want=1"); end
        @(posedge clk); #1;
        rst = 1'b1;
        rd0 = rd_pulses;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total += 3;
            if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_in_rst got=%b want=0", bus.rsp_valid); end
            if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_in_rst got=%b want=1", bus.req_ready); end
            if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
                bad++; $display("FAIL rmid_en_in_rst got=%b%b want=00", bus.mem_wr_en, bus.mem_rd_en);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total += 3;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_after got=%b want=0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b want=1", bus.req_ready); end
        if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            bad++; $display("FAIL rmid_en_after got=%b%b want=00", bus.mem_wr_en, bus.mem_rd_en);
        end
        repeat (8) @(negedge clk);
        total += 2;
        if (rd_pulses !== rd0)   begin bad++; $display("FAIL rmid_stray_rd got=%0d want=%0d", rd_pulses, rd0); end
        if (got_q.size() !== 0)  begin bad++; $display("FAIL rmid_stray_rsp got=%0d want=0", got_q.size()); end
        @(posedge clk); #1;
        send(1'b1, a, d, 4, ok);
        send(1'b0, a, 8'h00, 8, ok);
        wait_drain(40, okd);
        total++;
        if (!okd || got_q.size() !== 1 || got_q[0] !== d) begin
            bad++; $display("FAIL rmid_recover got_n=%0d want_n=1 want=%h", got_q.size(), d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_protocol();
        total += 2;
        if (viol_both !== 0)   begin bad++; $display("FAIL proto_both_enables got=%0d want=0", viol_both); end
        if (viol_stable !== 0) begin bad++; $display("FAIL proto_rsp_stable got=%0d want=0", viol_stable); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
